// File: rtl/sram_access_arbiter_if.sv
// Request/response and backend command signals shared by the audio path, the CPU path
// and the SRAM backend; the arbiter takes the slave view.

interface sram_access_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) ();
  logic              aud_req;
  logic              aud_wr;
  logic [ADDR_W-1:0] aud_addr;
  logic [DATA_W-1:0] aud_wdata;
  logic              aud_ack;
  logic [DATA_W-1:0] aud_rdata;

  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_start;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  aud_req, aud_wr, aud_addr, aud_wdata,
    output aud_ack, aud_rdata,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_start, mem_wr, mem_addr, mem_wdata,
    input  mem_busy, mem_done, mem_rdata
  );

  modport master (
    output aud_req, aud_wr, aud_addr, aud_wdata,
    input  aud_ack, aud_rdata,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_start, mem_wr, mem_addr, mem_wdata,
    output mem_busy, mem_done, mem_rdata
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM backend between audio and CPU: one transaction in flight, audio priority
// with a bounded audio streak so the CPU cannot starve, sticky timeout flag.

module sram_arb_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              done,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);
  assign ack = sel & done;

  // Read data is held between acks; writes never touch it.
  always_ff @(posedge clk) begin
    if (reset)            rdata <= '0;
    else if (sel && load) rdata <= load_data;
  end
endmodule

module sram_access_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int AUD_BURST   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_access_arbiter_if.slave bus,
  input  logic                 err_clr,
  output logic                 owner,
  output logic                 timeout_err
);
  localparam int NUM_REQ = 2;
  localparam int SW      = $clog2(AUD_BURST + 1);
  localparam int CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] BURST_MAX = SW'(AUD_BURST);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t                         state, state_nxt;
  logic [SW-1:0]                  streak, streak_nxt;
  logic [CW-1:0]                  cnt, cnt_nxt;
  cmd_t                           cmd_q;
  cmd_t [NUM_REQ-1:0]             cmd;
  logic [NUM_REQ-1:0]             req, ack;
  logic [NUM_REQ-1:0][DATA_W-1:0] rdata;
  logic                           go, grant_cpu, ld_rd, to_hit;
  logic [DATA_W-1:0]              rd_nxt;

  // Lane 0 is audio, lane 1 is CPU; owner doubles as the lane index.
  assign req    = {bus.cpu_req, bus.aud_req};
  assign cmd[0] = '{wr: bus.aud_wr, addr: bus.aud_addr, wdata: bus.aud_wdata};
  assign cmd[1] = '{wr: bus.cpu_wr, addr: bus.cpu_addr, wdata: bus.cpu_wdata};

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    cnt_nxt    = cnt;
    go         = 1'b0;
    grant_cpu  = 1'b0;
    ld_rd      = 1'b0;
    to_hit     = 1'b0;
    rd_nxt     = '0;
    case (state)
      S_IDLE: begin
        if (!bus.mem_busy && |req) begin
          go        = 1'b1;
          grant_cpu = req[1] & (~req[0] | (streak == BURST_MAX));
          state_nxt = S_ISSUE;
        end
        // Streak only counts audio wins that actually held the CPU off.
        if (!req[1])                                     streak_nxt = '0;
        else if (go && grant_cpu)                        streak_nxt = '0;
        else if (go && streak != BURST_MAX)              streak_nxt = streak + 1'b1;
      end
      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still counts as a normal completion.
        if (bus.mem_done) begin
          state_nxt = S_DONE;
          ld_rd     = ~cmd_q.wr;
          rd_nxt    = bus.mem_rdata;
        end else if (cnt == TO_LAST) begin
          state_nxt = S_DONE;
          ld_rd     = ~cmd_q.wr;
          to_hit    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      streak      <= '0;
      cnt         <= '0;
      cmd_q       <= '0;
      owner       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      cnt    <= cnt_nxt;
      if (go) begin
        cmd_q <= grant_cpu ? cmd[1] : cmd[0];
        owner <= grant_cpu;
      end
      if (to_hit)       timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sram_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .sel       (owner == 1'(i)),
      .done      (state == S_DONE),
      .load      (ld_rd),
      .load_data (rd_nxt),
      .ack       (ack[i]),
      .rdata     (rdata[i])
    );
  end

  assign bus.aud_ack   = ack[0];
  assign bus.aud_rdata = rdata[0];
  assign bus.cpu_ack   = ack[1];
  assign bus.cpu_rdata = rdata[1];

  assign bus.mem_start = (state == S_ISSUE);
  assign bus.mem_wr    = cmd_q.wr;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;

  a_start_pulse: assert property (@(posedge clk) disable iff (reset)
    bus.mem_start |=> !bus.mem_start);
  a_ack_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.aud_ack && bus.cpu_ack));
  a_ack_pulse: assert property (@(posedge clk) disable iff (reset)
    (bus.aud_ack || bus.cpu_ack) |=> !(bus.aud_ack || bus.cpu_ack));
endmodule
